wb_stage_p: RTL and testbench
=============================

WB_STAGE_P -- requirements
Module: wb_stage_p

Interface
REQ-001 Parameter LINK_OFF, default 8, byte offset added to the captured pc for link writes (jal/jalr).
REQ-002 Parameter CNT_W, default 32, width of retire counter.
REQ-003 Parameter ZERO_REG_WE, default 0; when 0, reg_we is suppressed for destination register 0.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 in_valid  input  1  M-stage entry holds a real instruction.
REQ-007 instr_m, pc_m, aluout_m, memdata_m  input  32 each  M-stage instruction, pc, ALU result, raw memory word.
REQ-008 wb_stall  input  1  hold current WB entry (no capture).
REQ-009 flush  input  1  replace the WB entry with a bubble.
REQ-010 wb_valid  output  1  WB entry valid.
REQ-011 reg_we  output  1  register-file write enable.
REQ-012 wb_addr  output  5  destination register.
REQ-013 wb_data  output  32  write data; also the forwarding value.
REQ-014 bypass_instr  output  32  captured instruction (0 when bubble).
REQ-015 bypass_cal_r, bypass_cal_i, is_jal, is_jalr  output  1 each  instruction-class flags for hazard logic.
REQ-016 align_err  output  1  captured load is misaligned.
REQ-017 retire_cnt  output  CNT_W  retired-instruction count.

Function
REQ-018 Register update priority per edge: flush > wb_stall > capture; flush loads a bubble (valid=0, instr=0, pc/alu/mem=0).
REQ-019 Capture (no flush, no stall): valid<=in_valid, instr/pc/alu/mem <= *_m; in_valid=0 captures a bubble.
REQ-020 Stall without flush: all registers hold; outputs remain stable.
REQ-021 Decode is combinational from the captured instr; latency in->out = 1 cycle.
REQ-022 Classes: cal_r = opcode 0 and funct not jr(001000)/jalr(001001); cal_i = addi/addiu/andi/ori/xori/lui/slti/sltiu; load = lw/lb/lbu/lh/lhu; jal = 000011; jalr = opcode 0 and funct 001001; flags are 0 when wb_valid=0.
REQ-023 Destination: cal_r/jalr -> instr[15:11]; cal_i/load -> instr[20:16]; jal -> 31.
REQ-024 Data select: jal/jalr -> pc+LINK_OFF (mod 2^32); load -> extended memory data; else aluout.
REQ-025 Load extension by alu[1:0]: lb/lbu select byte alu[1:0] (byte 0 = bits 7:0), sign/zero extend; lh/lhu select half alu[1] (half 0 = bits 15:0), sign/zero extend; lw passes word.
REQ-026 align_err=1 when valid load is lh/lhu with alu[0]=1, or lw with alu[1:0]!=0.
REQ-027 reg_we = wb_valid & writes-class & ~align_err & (wb_addr!=0 | ZERO_REG_WE).
REQ-028 Repeated reg_we during stall is allowed (idempotent write of identical data).
REQ-029 retire_cnt increments by 1 on each edge where wb_valid=1, wb_stall=0, flush=0; it wraps modulo 2^CNT_W; a flushed or stalled entry is not counted.
REQ-030 Unrecognised opcode with valid=1: no flags, reg_we=0, counted as retired.

Reset
REQ-031 reset asserted: immediately wb_valid=0, bypass_instr=0, all flags 0, reg_we=0, align_err=0, wb_addr=0, wb_data=0, retire_cnt=0.
REQ-032 Reset mid-stall or mid-flush overrides both; first capture occurs on the first rising edge after reset deasserts.

Verification
REQ-033 addu $3,$1,$2 with alu=0x00000005 captured -> next cycle reg_we=1, wb_addr=3, wb_data=0x5, bypass_cal_r=1, retire_cnt 0->1 on the following edge.
REQ-034 lb $4 with alu=0x1003, mem=0x80FFFFFF -> wb_data=0xFFFFFF80; lbu same -> 0x00000080; lh alu=0x1002, mem=0x8001_0000 -> 0xFFFF8001.
REQ-035 jal at pc=0x3000 -> wb_addr=31, wb_data=0x3008, is_jal=1; jalr $5 -> wb_addr=5, wb_data=pc+8.
REQ-036 lw with alu=0x1002 -> align_err=1, reg_we=0; addiu $0 -> reg_we=0 (ZERO_REG_WE=0).
REQ-037 wb_stall held 3 cycles with valid entry -> outputs constant, retire_cnt unchanged; flush+stall same edge -> bubble, wb_valid=0.
REQ-038 CNT_W=4, 17 retiring instructions -> retire_cnt=1; reset asserted mid-stream asynchronously -> all outputs 0 before next edge.

Source files
------------

// File: rtl/wb_stage_p.sv
// Write-back pipeline stage: captures the M-stage entry, decodes its class,
// selects/extends the write data, and counts retired instructions.
module wb_stage_p #(
   parameter int unsigned LINK_OFF    = 8,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned ZERO_REG_WE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [31:0]      instr_m,
   input  logic [31:0]      pc_m,
   input  logic [31:0]      aluout_m,
   input  logic [31:0]      memdata_m,
   input  logic             wb_stall,
   input  logic             flush,
   output logic             wb_valid,
   output logic             reg_we,
   output logic [4:0]       wb_addr,
   output logic [31:0]      wb_data,
   output logic [31:0]      bypass_instr,
   output logic             bypass_cal_r,
   output logic             bypass_cal_i,
   output logic             is_jal,
   output logic             is_jalr,
   output logic             align_err,
   output logic [CNT_W-1:0] retire_cnt
);

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_ADDI    = 6'b001000;
   localparam logic [5:0] OP_ADDIU   = 6'b001001;
   localparam logic [5:0] OP_SLTI    = 6'b001010;
   localparam logic [5:0] OP_SLTIU   = 6'b001011;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_XORI    = 6'b001110;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_LB      = 6'b100000;
   localparam logic [5:0] OP_LH      = 6'b100001;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_LBU     = 6'b100100;
   localparam logic [5:0] OP_LHU     = 6'b100101;
   localparam logic [5:0] FN_JR      = 6'b001000;
   localparam logic [5:0] FN_JALR    = 6'b001001;

   logic             r_valid;
   logic [31:0]      r_instr;
   logic [31:0]      r_pc;
   logic [31:0]      r_alu;
   logic [31:0]      r_mem;
   logic [CNT_W-1:0] r_cnt;

   logic [5:0]  w_op;
   logic [5:0]  w_funct;
   logic        w_cal_r;
   logic        w_cal_i;
   logic        w_load;
   logic        w_jal;
   logic        w_jalr;
   logic        w_align;
   logic [4:0]  w_addr;
   logic [31:0] w_load_data;
   logic [31:0] w_data;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Pipeline register: flush beats stall beats capture; bubbles are all-zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc    <= '0;
         r_alu   <= '0;
         r_mem   <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc    <= '0;
         r_alu   <= '0;
         r_mem   <= '0;
      end else if (!wb_stall) begin
         r_valid <= in_valid;
         r_instr <= in_valid ? instr_m   : 32'h0;
         r_pc    <= in_valid ? pc_m      : 32'h0;
         r_alu   <= in_valid ? aluout_m  : 32'h0;
         r_mem   <= in_valid ? memdata_m : 32'h0;
      end
   end

   // Retire counter: a valid entry leaving WB without flush or stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (r_valid && !wb_stall && !flush) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign w_op    = r_instr[31:26];
   assign w_funct = r_instr[5:0];

   // Instruction class decode; every flag is gated by entry validity.
   always_comb begin
      w_cal_r = 1'b0;
      w_cal_i = 1'b0;
      w_load  = 1'b0;
      w_jal   = 1'b0;
      w_jalr  = 1'b0;
      if (r_valid) begin
         case (w_op)
            OP_SPECIAL: begin
               w_jalr  = (w_funct == FN_JALR);
               w_cal_r = (w_funct != FN_JALR) && (w_funct != FN_JR);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: w_cal_i = 1'b1;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: w_load = 1'b1;
            OP_JAL:  w_jal = 1'b1;
            default: ;
         endcase
      end
   end

   // Load lane selection, extension and misalignment detection.
   always_comb begin
      w_byte      = r_mem[7:0];
      w_half      = r_alu[1] ? r_mem[31:16] : r_mem[15:0];
      w_load_data = r_mem;
      w_align     = 1'b0;
      case (r_alu[1:0])
         2'd0:    w_byte = r_mem[7:0];
         2'd1:    w_byte = r_mem[15:8];
         2'd2:    w_byte = r_mem[23:16];
         default: w_byte = r_mem[31:24];
      endcase
      case (w_op)
         OP_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
         OP_LBU: w_load_data = {24'h0, w_byte};
         OP_LH: begin
            w_load_data = {{16{w_half[15]}}, w_half};
            w_align     = r_alu[0];
         end
         OP_LHU: begin
            w_load_data = {16'h0, w_half};
            w_align     = r_alu[0];
         end
         OP_LW: begin
            w_load_data = r_mem;
            w_align     = (r_alu[1:0] != 2'd0);
         end
         default: ;
      endcase
      w_align = w_align & w_load;
   end

   // Destination register and write-data selection.
   always_comb begin
      w_addr = 5'd0;
      w_data = r_alu;
      if (w_cal_r || w_jalr) begin
         w_addr = r_instr[15:11];
      end else if (w_cal_i || w_load) begin
         w_addr = r_instr[20:16];
      end else if (w_jal) begin
         w_addr = 5'd31;
      end
      if (w_jal || w_jalr) begin
         w_data = r_pc + 32'(LINK_OFF);
      end else if (w_load) begin
         w_data = w_load_data;
      end
   end

   assign wb_valid     = r_valid;
   assign wb_addr      = w_addr;
   assign wb_data      = w_data;
   assign bypass_instr = r_instr;
   assign bypass_cal_r = w_cal_r;
   assign bypass_cal_i = w_cal_i;
   assign is_jal       = w_jal;
   assign is_jalr      = w_jalr;
   assign align_err    = w_align;
   assign reg_we       = (w_cal_r | w_cal_i | w_load | w_jal | w_jalr) & ~w_align &
                         ((w_addr != 5'd0) | (ZERO_REG_WE != 0));
   assign retire_cnt   = r_cnt;

endmodule

// File: tb/tb_wb_stage_p.sv
// Directed bench for wb_stage_p: table-driven decode/data vectors plus
// hand-written stall, flush, counter-wrap and async-reset sequences.
module tb_wb_stage_p;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [31:0] instr_m, pc_m, aluout_m, memdata_m;
   logic        wb_stall, flush;

   logic        wb_valid, reg_we, bypass_cal_r, bypass_cal_i, is_jal, is_jalr, align_err;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data, bypass_instr, retire_cnt;

   logic        s_valid, s_we, s_cr, s_ci, s_jal, s_jalr, s_al;
   logic [4:0]  s_addr;
   logic [31:0] s_data, s_instr;
   logic [3:0]  s_cnt;

   int errors = 0;
   int checks = 0;
   int exp_cnt = 0;
   logic exp_valid = 1'b0;

   wb_stage_p dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .instr_m(instr_m), .pc_m(pc_m),
      .aluout_m(aluout_m), .memdata_m(memdata_m), .wb_stall(wb_stall), .flush(flush),
      .wb_valid(wb_valid), .reg_we(reg_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .bypass_instr(bypass_instr), .bypass_cal_r(bypass_cal_r), .bypass_cal_i(bypass_cal_i),
      .is_jal(is_jal), .is_jalr(is_jalr), .align_err(align_err), .retire_cnt(retire_cnt)
   );

   wb_stage_p #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .instr_m(instr_m), .pc_m(pc_m),
      .aluout_m(aluout_m), .memdata_m(memdata_m), .wb_stall(wb_stall), .flush(flush),
      .wb_valid(s_valid), .reg_we(s_we), .wb_addr(s_addr), .wb_data(s_data),
      .bypass_instr(s_instr), .bypass_cal_r(s_cr), .bypass_cal_i(s_ci),
      .is_jal(s_jal), .is_jalr(s_jalr), .align_err(s_al), .retire_cnt(s_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] mem;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        cr;
      logic        ci;
      logic        jal;
      logic        jalr;
      logic        al;
   } vec_t;

   vec_t vecs[15];

   function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [5:0] fn);
      return {6'd0, 5'd1, 5'd2, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt);
      return {op, 5'd1, rt, 16'h0010};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // One rising edge; the reference valid/count model advances with it.
   task automatic step();
      if (!reset) begin
         if (exp_valid && !wb_stall && !flush) exp_cnt++;
         if (flush) exp_valid = 1'b0;
         else if (!wb_stall) exp_valid = in_valid;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] mem);
      in_valid = v; instr_m = ins; pc_m = pc; aluout_m = alu; memdata_m = mem;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".valid"}, 32'(wb_valid), 32'h0);
      chk({tag, ".instr"}, bypass_instr, 32'h0);
      chk({tag, ".flags"}, 32'({bypass_cal_r, bypass_cal_i, is_jal, is_jalr, align_err, reg_we}), 32'h0);
      chk({tag, ".addr"}, 32'(wb_addr), 32'h0);
      chk({tag, ".data"}, wb_data, 32'h0);
      chk({tag, ".cnt"}, retire_cnt, 32'h0);
      chk({tag, ".cnt4"}, 32'(s_cnt), 32'h0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      exp_cnt = 0;
      exp_valid = 1'b0;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      wb_stall = 1'b0; flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

      //          instr                         pc          alu          mem         we  addr  data        cr ci jl jr al
      vecs[0]  = '{enc_r(5'd3, 6'b100001),     32'h0,      32'h5,       32'h0,      1, 5'd3,  32'h5,        1, 0, 0, 0, 0};
      vecs[1]  = '{enc_i(6'b100000, 5'd4),     32'h0,      32'h1003,    32'h80FFFFFF, 1, 5'd4, 32'hFFFFFF80, 0, 0, 0, 0, 0};
      vecs[2]  = '{enc_i(6'b100100, 5'd4),     32'h0,      32'h1003,    32'h80FFFFFF, 1, 5'd4, 32'h00000080, 0, 0, 0, 0, 0};
      vecs[3]  = '{enc_i(6'b100001, 5'd4),     32'h0,      32'h1002,    32'h80010000, 1, 5'd4, 32'hFFFF8001, 0, 0, 0, 0, 0};
      vecs[4]  = '{enc_i(6'b100101, 5'd4),     32'h0,      32'h1002,    32'h80010000, 1, 5'd4, 32'h00008001, 0, 0, 0, 0, 0};
      vecs[5]  = '{enc_i(6'b100011, 5'd4),     32'h0,      32'h1000,    32'h12345678, 1, 5'd4, 32'h12345678, 0, 0, 0, 0, 0};
      vecs[6]  = '{{6'b000011, 26'h0C00},      32'h3000,   32'h0,       32'h0,      1, 5'd31, 32'h3008,     0, 0, 1, 0, 0};
      vecs[7]  = '{enc_r(5'd5, 6'b001001),     32'h4000,   32'h0,       32'h0,      1, 5'd5,  32'h4008,     0, 0, 0, 1, 0};
      vecs[8]  = '{enc_i(6'b100011, 5'd4),     32'h0,      32'h1002,    32'hDEADBEEF, 0, 5'd4, 32'hDEADBEEF, 0, 0, 0, 0, 1};
      vecs[9]  = '{enc_i(6'b001001, 5'd0),     32'h0,      32'h7,       32'h0,      0, 5'd0,  32'h7,        0, 1, 0, 0, 0};
      vecs[10] = '{enc_i(6'b001111, 5'd9),     32'h0,      32'hABCD0000, 32'h0,     1, 5'd9,  32'hABCD0000, 0, 1, 0, 0, 0};
      vecs[11] = '{enc_i(6'b100001, 5'd6),     32'h0,      32'h1001,    32'h1234F00D, 0, 5'd6, 32'hFFFFF00D, 0, 0, 0, 0, 1};
      vecs[12] = '{{6'b111111, 26'h0},         32'h0,      32'h55,      32'h0,      0, 5'd0,  32'h55,       0, 0, 0, 0, 0};
      vecs[13] = '{enc_r(5'd0, 6'b001000),     32'h0,      32'h66,      32'h0,      0, 5'd0,  32'h66,       0, 0, 0, 0, 0};
      vecs[14] = '{enc_i(6'b100100, 5'd7),     32'h0,      32'h1001,    32'h0000AB00, 1, 5'd7, 32'h000000AB, 0, 0, 0, 0, 0};

      // Reset state
      #2;
      chk_zero("reset");
      do_reset();

      // Table: one vector captured per edge, outputs valid one cycle later
      foreach (vecs[i]) begin
         drive(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].alu, vecs[i].mem);
         step();
         chk($sformatf("v%0d.valid", i), 32'(wb_valid), 32'h1);
         chk($sformatf("v%0d.we", i), 32'(reg_we), 32'(vecs[i].we));
         chk($sformatf("v%0d.addr", i), 32'(wb_addr), 32'(vecs[i].addr));
         chk($sformatf("v%0d.data", i), wb_data, vecs[i].data);
         chk($sformatf("v%0d.flags", i),
             32'({bypass_cal_r, bypass_cal_i, is_jal, is_jalr, align_err}),
             32'({vecs[i].cr, vecs[i].ci, vecs[i].jal, vecs[i].jalr, vecs[i].al}));
         chk($sformatf("v%0d.instr", i), bypass_instr, vecs[i].instr);
         chk($sformatf("v%0d.cnt", i), retire_cnt, 32'(exp_cnt));
      end

      // Stall for three cycles holds outputs and count
      drive(1'b1, enc_r(5'd3, 6'b100001), 32'h0, 32'h11, 32'h0);
      step();
      wb_stall = 1'b1;
      drive(1'b1, enc_i(6'b100011, 5'd8), 32'h0, 32'h2000, 32'hCAFEF00D);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall.valid", 32'(wb_valid), 32'h1);
         chk("stall.addr", 32'(wb_addr), 32'd3);
         chk("stall.data", wb_data, 32'h11);
         chk("stall.we", 32'(reg_we), 32'h1);
         chk("stall.cnt", retire_cnt, 32'(exp_cnt));
      end

      // Flush and stall on the same edge: bubble, not counted
      flush = 1'b1;
      step();
      chk("fls.valid", 32'(wb_valid), 32'h0);
      chk("fls.instr", bypass_instr, 32'h0);
      chk("fls.we", 32'(reg_we), 32'h0);
      chk("fls.data", wb_data, 32'h0);
      chk("fls.cnt", retire_cnt, 32'(exp_cnt));
      flush = 1'b0; wb_stall = 1'b0;

      // Flush alone discards a valid entry
      drive(1'b1, enc_r(5'd10, 6'b100001), 32'h0, 32'h9, 32'h0);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush.valid", 32'(wb_valid), 32'h0);
      chk("flush.cnt", retire_cnt, 32'(exp_cnt));

      // in_valid low captures a bubble
      drive(1'b0, enc_r(5'd11, 6'b100001), 32'h0, 32'h9, 32'h0);
      step();
      chk("bub.valid", 32'(wb_valid), 32'h0);
      chk("bub.instr", bypass_instr, 32'h0);
      chk("bub.we", 32'(reg_we), 32'h0);

      // 17 retirements: 32-bit counter reads 17, 4-bit counter wraps to 1
      do_reset();
      drive(1'b1, enc_r(5'd3, 6'b100001), 32'h0, 32'h1, 32'h0);
      for (int k = 0; k < 17; k++) step();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      step();
      chk("cnt17", retire_cnt, 32'(exp_cnt));
      chk("cnt17.wrap4", 32'(s_cnt), 32'(exp_cnt % 16));

      // Asynchronous reset mid-stream clears outputs before the next edge
      drive(1'b1, {6'b000011, 26'h0}, 32'h7000, 32'h0, 32'h0);
      step();
      step();
      #2;
      reset = 1'b1;
      wb_stall = 1'b1;
      flush = 1'b1;
      #1;
      chk_zero("areset");
      step();
      chk_zero("areset.held");
      @(negedge clk);
      reset = 1'b0; wb_stall = 1'b0; flush = 1'b0;
      exp_cnt = 0; exp_valid = 1'b0;
      drive(1'b1, {6'b000011, 26'h0}, 32'h5000, 32'h0, 32'h0);
      step();
      chk("post.jal", 32'(is_jal), 32'h1);
      chk("post.addr", 32'(wb_addr), 32'd31);
      chk("post.data", wb_data, 32'h5008);
      chk("post.cnt", retire_cnt, 32'h0);
      step();
      chk("post.cnt1", retire_cnt, 32'(exp_cnt));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
